fft_frame_buffer: RTL and testbench
===================================

Name: fft_frame_buffer

Overview:
- Parametrised input-framing front end for the FFT datapath.
- Accepts a gated stream of filtered samples and maintains a sliding window of the last NPT samples.
- Converts each sample to the FFT fixed-point format and emits a full NPT-wide frame every HOP accepted samples.
- Supports overlapping frames (HOP < NPT), gaps in the input stream, and a finite or unlimited frame budget with a done pulse.

Parameters:
- NPT, 16: window/FFT size; power of two, 4..64.
- DATA_W, 16: input sample width, signed.
- OUT_W, 32: frame element width, signed; DATA_W+FRAC <= OUT_W is required.
- FRAC, 16: left shift applied to each sample (number of fractional bits in the output).
- HOP, 16: accepted samples between consecutive frames; 1..NPT.
- NUM_FRAMES, 63: frames per run before done; 0 = unlimited, done never asserted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_d is accepted on this edge.
- in_d  in  DATA_W  signed sample.
- frame_valid  out  1  one-cycle pulse; frame_data holds a new frame.
- frame_data  out  NPT*OUT_W  slot k at bits [k*OUT_W +: OUT_W].
- frame_cnt  out  16  frames emitted in the current run.
- busy  out  1  high in FILL or RUN.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async): window, frame_data, frame_cnt, fill/hop counters = 0; frame_valid = busy = done = 0; FSM = IDLE.
- Sample conversion: element = sign_extend(in_d, OUT_W) << FRAC, zero-filled LSBs.
  - Example: in_d = 16'h0001 gives 32'h00010000; in_d = 16'h8000 gives 32'h80000000.
- Window: shifts only on edges where in_valid = 1. Element 0 is the oldest sample, element NPT-1 is the newest.
- Capture edge: frame_data is loaded with the window including the sample accepted on that same edge. frame_valid is 1 for the following cycle only. frame_data holds until the next capture edge.
- FSM, IDLE:
  - in_valid: accept the sample, fill_cnt = 1, frame_cnt = 0, go to FILL.
  - NPT = 1 is not supported.
- FSM, FILL:
  - Each accepted sample increments fill_cnt.
  - On the NPT-th accepted sample: capture, frame_cnt + 1, hop_cnt = 0, go to RUN.
- FSM, RUN:
  - Each accepted sample increments hop_cnt.
  - When hop_cnt reaches HOP: capture, frame_cnt + 1, hop_cnt = 0.
  - If this capture is frame NUM_FRAMES (NUM_FRAMES ≠ 0): go to DONE instead.
- FSM, DONE:
  - done = 1 for exactly one cycle, which is the same cycle as the last frame_valid.
  - in_valid is ignored in this cycle.
  - Then go to IDLE; window contents are retained but unused.
- Restart: the next run needs NPT fresh samples before its first frame. Stale window data is never emitted as a complete frame.
- Idle cycles (in_valid = 0): no shift, no counter change, frame_valid = 0. Frame timing depends only on the count of accepted samples, not on cycle count.
- Wrap-around: frame_cnt saturates at 16'hFFFF in unlimited mode.
- Counters and window are cleared only by reset and by entry to FILL (counters only).
- Reset mid-run: immediate return to reset values. Any pending frame is discarded.
- busy = 1 in FILL and RUN, 0 in IDLE and DONE.

Optional Feature:
- Macro: FFT_FRAME_BITREV_EN.
- Defined: frame_data slot k carries window element bitrev(k, log2 NPT). This is the input order needed by in-place DIT stages.
- Undefined: natural order, slot k = window element k.
- All timing is identical in both builds.

Test Plan:
- NPT=16, HOP=16, NUM_FRAMES=0; in_d = 1..48 with in_valid held high.
  - frame_valid pulses after samples 16, 32 and 48.
  - Frame 1: slot0 = 32'h00010000, slot15 = 32'h00100000. Frame 3: slot0 = 33<<16.
  - frame_cnt = 3; busy stays 1.
- HOP=4, in_d = 1..24.
  - Frames after samples 16, 20 and 24.
  - Frame 2: slot0 = 5<<16, slot15 = 20<<16.
  - in_d = 16'h8000 as the newest sample gives slot15 = 32'h80000000.
- Stream 1..32 with random 0-3 idle cycles between samples.
  - Frame contents and frame count match the gap-free run.
  - frame_valid is never asserted on an idle cycle.
- NUM_FRAMES=3, HOP=16, 80 samples.
  - done pulses together with the 3rd frame_valid; busy drops.
  - The sample arriving in the DONE cycle is ignored.
  - The next samples restart FILL; the first frame of the new run appears after 16 new accepted samples, with frame_cnt = 1.
- rst asserted after 10 samples of FILL.
  - All outputs are 0 immediately.
  - The next frame requires 16 post-reset samples.
- With FFT_FRAME_BITREV_EN defined, NPT=16, in_d = 1..16.
  - slot1 = 9<<16 and slot8 = 2<<16.
  - Without the macro: slot1 = 2<<16.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// Sliding-window framing front end for the FFT: converts samples to fixed point and emits an NPT-wide frame every HOP accepted samples.
// Build option: define FFT_FRAME_BITREV_EN to emit frame slots in bit-reversed window order.
module fft_frame_buffer #(
   parameter int NPT        = 16,
   parameter int DATA_W     = 16,
   parameter int OUT_W      = 32,
   parameter int FRAC       = 16,
   parameter int HOP        = 16,
   parameter int NUM_FRAMES = 63
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_d,
   output logic                     frame_valid,
   output logic [NPT*OUT_W-1:0]     frame_data,
   output logic [15:0]              frame_cnt,
   output logic                     busy,
   output logic                     done
);

   localparam int CW = $clog2(NPT + 1);
`ifdef FFT_FRAME_BITREV_EN
   localparam int LOG2 = $clog2(NPT);
`endif

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

   state_t                    state;
   logic [CW-1:0]             fill_cnt;
   logic [CW-1:0]             hop_cnt;
   logic signed [OUT_W-1:0]   win     [NPT];
   logic signed [OUT_W-1:0]   win_nxt [NPT];
   logic [NPT*OUT_W-1:0]      frame_nxt;
   logic [15:0]               cnt_inc;
   logic                      accept;
   logic                      capture;
   logic                      last;

   function automatic logic signed [OUT_W-1:0] to_fixed(input logic signed [DATA_W-1:0] d);
      logic signed [OUT_W-1:0] ext;
      ext = OUT_W'(d);
      return ext <<< FRAC;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   function automatic int slot_src(input int k);
`ifdef FFT_FRAME_BITREV_EN
      int r;
      r = 0;
      for (int b = 0; b < LOG2; b++)
         if (((k >> b) & 1) != 0) r = r | (1 << (LOG2 - 1 - b));
      return r;
`else
      return k;
`endif
   endfunction

   // Next window including the sample on this edge, so a capture sees the newest sample
   always_comb begin
      for (int i = 0; i < NPT - 1; i++) win_nxt[i] = win[i + 1];
      win_nxt[NPT-1] = to_fixed(in_d);
      frame_nxt = '0;
      for (int k = 0; k < NPT; k++) frame_nxt[k*OUT_W +: OUT_W] = win_nxt[slot_src(k)];
   end

   assign accept  = in_valid && (state != S_DONE);
   assign capture = in_valid && (((state == S_FILL) && (fill_cnt == CW'(NPT - 1))) ||
                                 ((state == S_RUN)  && (hop_cnt  == CW'(HOP - 1))));
   assign cnt_inc = sat_inc(frame_cnt);
   assign last    = (NUM_FRAMES != 0) && (cnt_inc == 16'(NUM_FRAMES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         fill_cnt    <= '0;
         hop_cnt     <= '0;
         frame_cnt   <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         for (int i = 0; i < NPT; i++) win[i] <= '0;
      end else begin
         frame_valid <= 1'b0;
         done        <= 1'b0;
         if (accept)
            for (int i = 0; i < NPT; i++) win[i] <= win_nxt[i];
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  fill_cnt  <= CW'(1);
                  hop_cnt   <= '0;
                  frame_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= S_FILL;
               end
            end
            S_FILL: begin
               if (in_valid) fill_cnt <= fill_cnt + CW'(1);
            end
            S_RUN: begin
               if (in_valid && !capture) hop_cnt <= hop_cnt + CW'(1);
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Capture overrides the per-state updates above
         if (capture) begin
            frame_data  <= frame_nxt;
            frame_valid <= 1'b1;
            frame_cnt   <= cnt_inc;
            hop_cnt     <= '0;
            if (last) begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               state <= S_RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: three instances (HOP 16 unlimited, HOP 4 unlimited, HOP 16 with 3-frame budget).
module tb_fft_frame_buffer;
   localparam int NPT = 16;
   localparam int OW  = 32;
   localparam int FW  = NPT * OW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [15:0]   din;
   logic          vld  [3];
   logic          fv   [3];
   logic [FW-1:0] fd   [3];
   logic [15:0]   fc   [3];
   logic          bsy  [3];
   logic          dn   [3];

   fft_frame_buffer #(.NPT(NPT), .DATA_W(16), .OUT_W(OW), .FRAC(16), .HOP(16), .NUM_FRAMES(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_d(din), .frame_valid(fv[0]),
      .frame_data(fd[0]), .frame_cnt(fc[0]), .busy(bsy[0]), .done(dn[0]));
   fft_frame_buffer #(.NPT(NPT), .DATA_W(16), .OUT_W(OW), .FRAC(16), .HOP(4), .NUM_FRAMES(0)) u_b (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_d(din), .frame_valid(fv[1]),
      .frame_data(fd[1]), .frame_cnt(fc[1]), .busy(bsy[1]), .done(dn[1]));
   fft_frame_buffer #(.NPT(NPT), .DATA_W(16), .OUT_W(OW), .FRAC(16), .HOP(16), .NUM_FRAMES(3)) u_c (
      .clk(clk), .rst(rst), .in_valid(vld[2]), .in_d(din), .frame_valid(fv[2]),
      .frame_data(fd[2]), .frame_cnt(fc[2]), .busy(bsy[2]), .done(dn[2]));

   typedef struct { logic [FW-1:0] frame; logic [15:0] cnt; } exp_t;
   typedef struct { int fidx; int slot; logic [31:0] val; } spot_t;

   exp_t          sb [$];
   logic [FW-1:0] got [$];
   spot_t         spots [17];

   int pass_cnt = 0;
   int total    = 0;
   int sel      = 0;

   // Reference model state: 0 idle, 1 fill, 2 run, 3 done
   int          mstate, mfill, mhop, mhop_p, mnf;
   logic [31:0] mwin [NPT];
   logic [15:0] mfcnt;
   logic        exp_fv, exp_done;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic int bitrev4(input int k);
      return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
   endfunction

   task automatic model_reset();
      mstate = 0; mfill = 0; mhop = 0; mfcnt = '0; exp_fv = 0; exp_done = 0;
      for (int i = 0; i < NPT; i++) mwin[i] = '0;
   endtask

   task automatic model_step(input logic v, input logic [15:0] d);
      logic          cap;
      exp_t          e;
      int            src;
      exp_fv = 0; exp_done = 0; cap = 0;
      if (mstate == 3) begin
         mstate = 0;
         return;
      end
      if (!v) return;
      for (int i = 0; i < NPT - 1; i++) mwin[i] = mwin[i + 1];
      mwin[NPT-1] = {d, 16'h0000};
      case (mstate)
         0: begin mfill = 1; mfcnt = '0; mhop = 0; mstate = 1; end
         1: begin if (mfill == NPT - 1) cap = 1; mfill++; end
         default: begin if (mhop == mhop_p - 1) cap = 1; else mhop++; end
      endcase
      if (cap) begin
         mhop = 0;
         if (mfcnt != 16'hFFFF) mfcnt++;
         for (int k = 0; k < NPT; k++) begin
`ifdef FFT_FRAME_BITREV_EN
            src = bitrev4(k);
`else
            src = k;
`endif
            e.frame[k*OW +: OW] = mwin[src];
         end
         e.cnt = mfcnt;
         sb.push_back(e);
         exp_fv = 1;
         if (mnf != 0 && int'(mfcnt) == mnf) begin
            mstate = 3; exp_done = 1;
         end else mstate = 2;
      end
   endtask

   task automatic cycle(input logic v, input logic [15:0] d);
      exp_t e;
      din = d;
      for (int i = 0; i < 3; i++) vld[i] = (i == sel) && v;
      model_step(v, d);
      @(posedge clk);
      #1;
      check("frame_valid", FW'(fv[sel]), FW'(exp_fv));
      check("done", FW'(dn[sel]), FW'(exp_done));
      check("busy", FW'(bsy[sel]), FW'(mstate == 1 || mstate == 2));
      check("frame_cnt", FW'(fc[sel]), FW'(mfcnt));
      if (exp_fv && sb.size() > 0) begin
         e = sb.pop_front();
         got.push_back(fd[sel]);
         check("frame_data", fd[sel], e.frame);
         check("frame_cnt_at_frame", FW'(fc[sel]), FW'(e.cnt));
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) vld[i] = 1'b0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_frame_valid", FW'(fv[sel]), '0);
      check("rst_frame_data", fd[sel], '0);
      check("rst_frame_cnt", FW'(fc[sel]), '0);
      check("rst_busy", FW'(bsy[sel]), '0);
      check("rst_done", FW'(dn[sel]), '0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [FW-1:0] fr;
      din = '0;
      for (int i = 0; i < 3; i++) vld[i] = 1'b0;
      spots[0]  = '{0, 0, 32'h0001_0000};
      spots[1]  = '{0, 15, 32'h0010_0000};
      spots[2]  = '{2, 0, 32'h0021_0000};
      spots[3]  = '{4, 0, 32'h0005_0000};
      spots[4]  = '{4, 15, 32'h0014_0000};
      spots[5]  = '{6, 15, 32'h8000_0000};
      spots[6]  = '{6, 0, 32'h000D_0000};
      spots[7]  = '{7, 0, 32'h0001_0000};
      spots[8]  = '{8, 15, 32'h0020_0000};
      spots[9]  = '{9, 0, 32'h0001_0000};
      spots[10] = '{11, 0, 32'h0021_0000};
      spots[11] = '{12, 0, 32'h0032_0000};
      spots[12] = '{12, 15, 32'h0041_0000};
      spots[13] = '{13, 0, 32'h00C9_0000};
      spots[14] = '{13, 15, 32'h00D8_0000};
`ifdef FFT_FRAME_BITREV_EN
      spots[15] = '{0, 1, 32'h0009_0000};
      spots[16] = '{0, 8, 32'h0002_0000};
`else
      spots[15] = '{0, 1, 32'h0002_0000};
      spots[16] = '{0, 8, 32'h0009_0000};
`endif

      // Non-overlapping frames, unlimited budget
      sel = 0; mhop_p = 16; mnf = 0;
      do_reset();
      for (int i = 1; i <= 48; i++) cycle(1'b1, 16'(i));
      repeat (2) cycle(1'b0, '0);

      // Overlapping frames, most-negative newest sample
      sel = 1; mhop_p = 4; mnf = 0;
      do_reset();
      for (int i = 1; i <= 27; i++) cycle(1'b1, 16'(i));
      cycle(1'b1, 16'h8000);
      cycle(1'b0, '0);

      // Gapped stream
      sel = 0; mhop_p = 16; mnf = 0;
      do_reset();
      for (int i = 1; i <= 32; i++) begin
         cycle(1'b1, 16'(i));
         repeat ($urandom_range(3, 0)) cycle(1'b0, '0);
      end

      // Finite budget, sample during DONE ignored, restart
      sel = 2; mhop_p = 16; mnf = 3;
      do_reset();
      for (int i = 1; i <= 80; i++) cycle(1'b1, 16'(i));
      repeat (2) cycle(1'b0, '0);

      // Reset in the middle of FILL
      sel = 0; mhop_p = 16; mnf = 0;
      do_reset();
      for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(100 + i));
      do_reset();
      for (int i = 1; i <= 16; i++) cycle(1'b1, 16'(200 + i));
      cycle(1'b0, '0);

      check("frame_total", FW'(got.size()), FW'(14));
      check("scoreboard_drained", FW'(sb.size()), '0);
      for (int i = 0; i < 17; i++) begin
         fr = (spots[i].fidx < got.size()) ? got[spots[i].fidx] : 'x;
         check($sformatf("spot_f%0d_s%0d", spots[i].fidx, spots[i].slot),
               FW'(fr[spots[i].slot*OW +: OW]), FW'(spots[i].val));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
